// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//
// Fetch stage for the 8-bit RISC core. Owns the program counter and issues
// one instruction-memory request at a time. Returned words, tagged with their
// fetch address, go into a small prefetch FIFO. The FIFO feeds decode over a
// valid/ready handshake. Decode/execute may redirect fetch, which flushes the
// FIFO, or halt it, which only stops new requests.
//
// Ports
//   clk            : clock, rising edge
//   rst            : asynchronous active-low reset
//   imem_req       : registered fetch request, held until acked
//   imem_addr      : fetch address, stable while imem_req=1
//   imem_ack       : memory returned data (may coincide with request rise)
//   imem_rdata     : instruction word, valid with imem_ack
//   redirect_valid : load redirect_pc and flush the prefetch queue
//   redirect_pc    : redirect target
//   halt           : suppress new requests
//   instr_valid    : queue head valid
//   instr          : queue head instruction
//   instr_pc       : address the queue head was fetched from
//   instr_ready    : decode accepts queue head
//   fetch_pc       : next address to be requested
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
  parameter int                ADDR_W   = 8,
  parameter int                INSTR_W  = 16,
  parameter int                DEPTH    = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  input  logic               halt,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  input  logic               instr_ready,
  output logic [ADDR_W-1:0]  fetch_pc
);

  localparam int                PTR_W   = $clog2(DEPTH);
  localparam int                CNT_W   = PTR_W + 1;
  localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);
  localparam logic [PTR_W-1:0]  PTR_ONE = PTR_W'(1);
  localparam logic [ADDR_W-1:0] PC_ONE  = ADDR_W'(1);

  // DROP: a request issued before a redirect is still on the bus; its data
  // must be swallowed before fetching from the new target.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic               req_q, req_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [INSTR_W-1:0] q_instr_q [DEPTH];
  logic [ADDR_W-1:0]  q_pc_q    [DEPTH];

  logic               push;
  logic               pop;
  logic [CNT_W-1:0]   occ_post;

  // Redirect wins over both queue operations.
  assign push     = imem_ack && (state_q == S_REQ) && !redirect_valid;
  assign pop      = (cnt_q != '0) && instr_ready && !redirect_valid;
  assign occ_post = cnt_q + (push ? CNT_ONE : '0) - (pop ? CNT_ONE : '0);

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    addr_d     = addr_q;
    cnt_d      = occ_post;
    rd_ptr_d   = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    wr_ptr_d   = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;

    case (state_q)
      S_IDLE: begin
        if (!halt && (cnt_q < DEPTH_C)) begin
          state_d = S_REQ;
          addr_d  = fetch_pc_q;
        end
      end
      S_REQ: begin
        if (imem_ack) begin
          fetch_pc_d = fetch_pc_q + PC_ONE;
          // Keep streaming only if the word just pushed leaves room for the
          // next one, so count + outstanding never exceeds DEPTH.
          if (!halt && (occ_post < DEPTH_C)) begin
            addr_d = fetch_pc_q + PC_ONE;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_DROP: begin
        if (imem_ack) begin
          if (!halt) begin
            state_d = S_REQ;
            addr_d  = fetch_pc_q;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (redirect_valid) begin
      fetch_pc_d = redirect_pc;
      cnt_d      = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      // A request the bus has not yet answered cannot be withdrawn.
      if ((state_q != S_IDLE) && !imem_ack) begin
        state_d = S_DROP;
        addr_d  = addr_q;
      end else if (!halt) begin
        state_d = S_REQ;
        addr_d  = redirect_pc;
      end else begin
        state_d = S_IDLE;
        addr_d  = addr_q;
      end
    end

    req_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= RESET_PC;
      addr_q     <= RESET_PC;
      req_q      <= 1'b0;
      cnt_q      <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      addr_q     <= addr_d;
      req_q      <= req_d;
      cnt_q      <= cnt_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  // Queue storage; while in REQ, fetch_pc_q is the address being acked.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        q_instr_q[i] <= '0;
        q_pc_q[i]    <= '0;
      end
    end else if (push) begin
      q_instr_q[wr_ptr_q] <= imem_rdata;
      q_pc_q[wr_ptr_q]    <= fetch_pc_q;
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = addr_q;
  assign fetch_pc    = fetch_pc_q;
  assign instr_valid = (cnt_q != '0);
  assign instr       = q_instr_q[rd_ptr_q];
  assign instr_pc    = q_pc_q[rd_ptr_q];

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

  localparam int ADDR_W  = 8;
  localparam int INSTR_W = 16;
  localparam int DEPTH   = 2;

  logic               clk = 1'b0;
  logic               rst;
  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_rdata;
  logic               redirect_valid;
  logic [ADDR_W-1:0]  redirect_pc;
  logic               halt;
  logic               instr_valid;
  logic [INSTR_W-1:0] instr;
  logic [ADDR_W-1:0]  instr_pc;
  logic               instr_ready;
  logic [ADDR_W-1:0]  fetch_pc;

  always #5 clk = ~clk;

  instr_fetch_unit #(
    .ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .DEPTH(DEPTH), .RESET_PC(8'h00)
  ) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .halt(halt),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
    .instr_ready(instr_ready), .fetch_pc(fetch_pc)
  );

  // Memory: acks after mem_lat cycles of a held request; returns {A5, addr}.
  int lat_cnt;
  int mem_lat;
  always @(posedge clk or negedge rst) begin
    if (!rst) lat_cnt <= 0;
    else if (imem_req && !imem_ack) lat_cnt <= lat_cnt + 1;
    else lat_cnt <= 0;
  end
  assign imem_ack   = imem_req && (lat_cnt >= mem_lat);
  assign imem_rdata = {8'hA5, imem_addr};

  int checks   = 0;
  int failures = 0;

  // Reference model: program counter, one outstanding request, drop flag,
  // and a FIFO of {pc, word} expected at the decode side.
  logic [7:0]  m_pc;
  logic [7:0]  m_addr;
  bit          m_busy;
  bit          m_drop;
  logic [7:0]  q_pc[$];
  logic [15:0] q_ins[$];
  logic [7:0]  popped[$];

  function automatic logic [15:0] word(input logic [7:0] a);
    return {8'hA5, a};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 8'h00; m_addr = 8'h00; m_busy = 0; m_drop = 0;
    q_pc.delete(); q_ins.delete();
  endtask

  task automatic model_update();
    int  pre_cnt;
    bit  pop, ack, push, was_idle, was_drop, start;
    pre_cnt  = q_pc.size();
    pop      = (pre_cnt > 0) && instr_ready && !redirect_valid;
    ack      = imem_ack && m_busy;
    push     = ack && !m_drop && !redirect_valid;
    was_idle = !m_busy;
    was_drop = m_drop;
    if (redirect_valid) begin
      q_pc.delete(); q_ins.delete();
      m_pc = redirect_pc;
      if (m_busy && !ack) m_drop = 1;
      else begin
        m_drop = 0;
        m_busy = !halt;
        m_addr = m_pc;
      end
    end else begin
      if (pop) begin
        void'(q_pc.pop_front());
        void'(q_ins.pop_front());
      end
      if (push) begin
        q_pc.push_back(m_addr);
        q_ins.push_back(word(m_addr));
        m_pc = m_addr + 8'd1;
      end
      start = 0;
      if (was_idle) start = !halt && (pre_cnt < DEPTH);
      else if (ack) begin
        m_busy = 0;
        m_drop = 0;
        start  = was_drop ? !halt : (!halt && (q_pc.size() < DEPTH));
      end
      if (start) begin
        m_busy = 1;
        m_addr = m_pc;
      end
    end
  endtask

  task automatic check_outputs();
    chk("imem_req", 32'(imem_req), 32'(m_busy));
    if (m_busy) chk("imem_addr", 32'(imem_addr), 32'(m_addr));
    chk("fetch_pc", 32'(fetch_pc), 32'(m_pc));
    chk("instr_valid", 32'(instr_valid), 32'(q_pc.size() > 0));
    if (q_pc.size() > 0) begin
      chk("instr", 32'(instr), 32'(q_ins[0]));
      chk("instr_pc", 32'(instr_pc), 32'(q_pc[0]));
    end
  endtask

  // One clock: predict from pre-edge inputs, then compare after the edge.
  task automatic step();
    @(negedge clk);
    if (instr_valid && instr_ready && !redirect_valid) popped.push_back(instr_pc);
    model_update();
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  // Called at posedge+1; reset pulse lies entirely between clock edges.
  task automatic do_reset();
    rst = 1'b0;
    #3;
    rst = 1'b1;
    model_reset();
  endtask

  initial begin
    rst = 1'b0; redirect_valid = 1'b0; redirect_pc = 8'h00; halt = 1'b0;
    instr_ready = 1'b0; mem_lat = 0;
    model_reset();
    #12;
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_addr", 32'(imem_addr), 32'h00);
    chk("rst_fetch_pc", 32'(fetch_pc), 32'h00);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr", 32'(instr), 32'h0000);
    chk("rst_instr_pc", 32'(instr_pc), 32'h00);
    #5 rst = 1'b1;   // posedge+2

    // 1: zero-wait streaming
    instr_ready = 1'b1;
    popped.delete();
    repeat (6) step();
    chk("t1_npop", 32'(popped.size() >= 3), 32'd1);
    chk("t1_pc0", 32'(popped[0]), 32'h00);
    chk("t1_pc1", 32'(popped[1]), 32'h01);
    chk("t1_pc2", 32'(popped[2]), 32'h02);

    // 5: asynchronous reset mid-request
    chk("t5_req_before", 32'(imem_req), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("t5_req_async", 32'(imem_req), 32'd0);
    chk("t5_valid_async", 32'(instr_valid), 32'd0);
    rst = 1'b1;
    model_reset();
    step();
    chk("t5_first_req", 32'(imem_req), 32'd1);
    chk("t5_first_addr", 32'(imem_addr), 32'h00);

    // 2: decode stalled from reset
    do_reset();
    instr_ready = 1'b0;
    repeat (6) step();
    chk("t2_req_idle", 32'(imem_req), 32'd0);
    chk("t2_fetch_pc", 32'(fetch_pc), 32'h02);
    instr_ready = 1'b1;
    popped.delete();
    repeat (8) step();
    chk("t2_npop", 32'(popped.size() >= 3), 32'd1);
    chk("t2_pc0", 32'(popped[0]), 32'h00);
    chk("t2_pc1", 32'(popped[1]), 32'h01);
    chk("t2_pc2", 32'(popped[2]), 32'h02);

    // 3: redirect to FE, wrap-around
    redirect_valid = 1'b1; redirect_pc = 8'hFE;
    popped.delete();
    step();
    redirect_valid = 1'b0;
    repeat (8) step();
    chk("t3_npop", 32'(popped.size() >= 4), 32'd1);
    chk("t3_pc0", 32'(popped[0]), 32'hFE);
    chk("t3_pc1", 32'(popped[1]), 32'hFF);
    chk("t3_pc2", 32'(popped[2]), 32'h00);
    chk("t3_pc3", 32'(popped[3]), 32'h01);

    // 4: redirect while a slow request is outstanding
    do_reset();
    mem_lat = 3;
    instr_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (imem_req === 1'b1 && imem_addr === 8'h05) break;
      step();
    end
    chk("t4_reach_05", 32'(imem_req === 1'b1 && imem_addr === 8'h05), 32'd1);
    redirect_valid = 1'b1; redirect_pc = 8'h40;
    popped.delete();
    step();
    redirect_valid = 1'b0;
    chk("t4_hold_addr", 32'(imem_addr), 32'h05);
    repeat (20) step();
    chk("t4_npop", 32'(popped.size() >= 1), 32'd1);
    chk("t4_first_pc", 32'(popped[0]), 32'h40);

    // 6: halt with a request outstanding
    do_reset();
    mem_lat = 2;
    redirect_valid = 1'b1; redirect_pc = 8'h10;
    step();
    redirect_valid = 1'b0;
    halt = 1'b1;
    chk("t6_out_addr", 32'(imem_addr), 32'h10);
    popped.delete();
    repeat (8) step();
    chk("t6_req_halted", 32'(imem_req), 32'd0);
    chk("t6_npop", 32'(popped.size()), 32'd1);
    chk("t6_pc", 32'(popped[0]), 32'h10);
    halt = 1'b0;
    step();
    chk("t6_resume_req", 32'(imem_req), 32'd1);
    chk("t6_resume_addr", 32'(imem_addr), 32'h11);

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      if (i == 300) do_reset();
      if ($urandom_range(0, 19) == 0) mem_lat = $urandom_range(0, 3);
      instr_ready    = ($urandom_range(0, 3) != 0);
      halt           = ($urandom_range(0, 9) == 0);
      redirect_valid = ($urandom_range(0, 14) == 0);
      redirect_pc    = 8'($urandom);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Fetch stage directly upstream of the decode/execute FSM in the 8-bit RISC core. It owns the program counter and issues requests to instruction memory with one request outstanding at a time. Returned 16-bit words go into a small prefetch queue, and the queue feeds decode over a valid/ready handshake. Decode/execute can redirect fetch for jumps and branches, and can halt it.

Parameters:
ADDR_W, 8, program-counter and instruction-memory address width
INSTR_W, 16, instruction width
DEPTH, 2, prefetch queue entries (power of two, at least 2)
RESET_PC, 0, fetch address after reset

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous, active-low reset
imem_req  out  1  fetch request, registered
imem_addr  out  ADDR_W  fetch address, stable while imem_req=1
imem_ack  in  1  memory has returned data; may be high in the same cycle imem_req rises
imem_rdata  in  INSTR_W  instruction word, valid when imem_ack=1
redirect_valid  in  1  load a new PC and flush the queue
redirect_pc  in  ADDR_W  redirect target
halt  in  1  suppress new requests
instr_valid  out  1  queue head is valid
instr  out  INSTR_W  queue head instruction
instr_pc  out  ADDR_W  address the queue head was fetched from
instr_ready  in  1  decode accepts the queue head
fetch_pc  out  ADDR_W  next address to be requested

Behaviour:
Reset
- rst=0 acts immediately, without waiting for a clock edge.
- On reset: fetch_pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, queue count=0, instr_valid=0, instr=0, instr_pc=0, state=IDLE.

State machine
- States are IDLE, REQ and DROP.
- IDLE -> REQ when halt=0 and count < DEPTH. imem_req rises on that edge with imem_addr=fetch_pc.
- In REQ, imem_req and imem_addr are held until imem_ack=1 is sampled.
- On an ack in REQ (no redirect):
  - Push {fetch_pc, imem_rdata} into the queue.
  - fetch_pc <= fetch_pc+1, modulo 2^ADDR_W, so 0xFF wraps to 0x00.
  - Stay in REQ with the next address if halt=0 and the post-edge occupancy (count+1-pop) < DEPTH.
  - Otherwise go to IDLE with imem_req=0.
- This gives back-to-back fetch at 1 instruction per cycle with zero-wait memory and instr_ready=1.

Queue
- FIFO ordering.
- instr_valid=(count>0). instr and instr_pc come straight from the head storage flops.
- Pop occurs when instr_valid and instr_ready are both high.
- Push and pop in the same cycle leave count unchanged.
- Requests are gated so that count + outstanding never exceeds DEPTH; overflow is impossible.
- Latency: an ack at edge N into an empty queue makes instr_valid=1 from edge N.

Redirect (highest priority)
- On an edge with redirect_valid=1: count<=0 and fetch_pc<=redirect_pc.
  - A pop in the same cycle is ignored.
  - A push in the same cycle is discarded.
- If a request is outstanding and not acked that cycle: go to DROP.
  - imem_req stays high on the old address, because the bus protocol forbids withdrawal.
  - The acked data is discarded.
  - After that ack: REQ at redirect_pc if halt=0, else IDLE.
- If the redirect coincides with an ack, or no request is outstanding: next state is REQ at redirect_pc (IDLE if halt=1).
- A redirect while in DROP updates the target PC and the FSM stays in DROP.

Halt
- halt suppresses new requests only.
- An outstanding request completes and is queued normally.
- The queue keeps draining.
- Deasserting halt resumes fetch at fetch_pc.

General
- No combinational path from any input to imem_req, imem_addr, instr_valid, instr or instr_pc.

Test Plan:
1. Release reset; zero-wait memory returning {8'hA5, addr}; instr_ready=1.
   -> imem_addr=00,01,02 on consecutive cycles; instr_pc=00,01,02 one per cycle starting the cycle after the first ack; instr=A500, A501, A502.
2. instr_ready=0 from reset.
   -> after two acks, imem_req=0 and fetch_pc=02. Raising instr_ready delivers 00 then 01 with no duplicate or drop, after which fetch restarts at 02.
3. Redirect to FE with zero-wait memory.
   -> instr_pc sequence FE, FF, 00, 01 (wrap-around); no instruction from the pre-redirect stream appears after the redirect edge.
4. Memory latency 3 cycles; redirect to 40 while address 05 is outstanding.
   -> imem_addr held at 05 until ack; word 05 never presented; next imem_addr=40; next instr_pc=40.
5. Assert rst=0 mid-request, between clock edges.
   -> imem_req=0 and instr_valid=0 immediately; after release, the first imem_addr equals RESET_PC.
6. halt=1 with a request outstanding at 10.
   -> word 10 queued and delivered; no further imem_req. Set halt=0 -> next imem_addr=11.
